beep_seq: RTL and testbench
===========================

# beep_seq

Beep request sequencer for the counting game: the controlling end of the beeper's `st`/`over` handshake. Game logic posts requests of the form "beep N times". The block queues them and runs each request as N separate beeper bursts. For each burst it raises `st`, waits for `over`, then drops `st` for a fixed gap. A watchdog abandons a burst whose `over` never arrives.

## Interface
Parameters:
- `GAP_CYCLES`, default 200: `st`-low cycles between bursts of one request (200 ms at 1 kHz `clk`); min 2.
- `TIMEOUT_CYCLES`, default 2000: max cycles in RUN waiting for `over`.
- `FIFO_DEPTH`, default 4: request queue entries; power of 2.

Ports:
- `clk`, in, 1: system clock (same 1 kHz `clk` as the beeper).
- `rst_n`, in, 1: reset, synchronous and active-low.
- `req`, in, 1: request strobe; one request per high cycle.
- `req_n`, in, 3: burst count for the request; 0 = no-op.
- `req_ready`, out, 1: queue not full.
- `st`, out, 1: beeper start/run; low clears the beeper.
- `over`, in, 1: beeper burst finished; level, held until `st` goes low.
- `busy`, out, 1: FSM not IDLE, or queue non-empty.
- `done`, out, 1: 1-cycle pulse when a request completes or is abandoned.
- `err`, out, 1: sticky timeout flag.
- `err_clr`, in, 1: clears `err`.

## Operation
- Enqueue rule:
  - Accept when `req && req_ready && req_n != 0`.
  - `req_n == 0`, or `req` while full, is dropped silently.
  - No other indication is given for a dropped request.
- FSM states: IDLE, RUN, GAP.
  - IDLE: `st=0`. If the queue is non-empty, pop the head, load `remaining <= req_n`, and go to RUN.
  - RUN: `st=1`. `over` is ignored in the first RUN cycle (blanking for a stale `over`). After that, `over==1` decrements `remaining`.
    - If the decremented `remaining` is 0: go to IDLE and pulse `done`.
    - Otherwise: go to GAP and clear the gap counter.
  - RUN timeout: the timeout counter reaching `TIMEOUT_CYCLES-1` without `over` does the following.
    - Sets `err`.
    - Discards the remaining bursts of the request.
    - Pulses `done`.
    - Goes to GAP with `remaining` forced to 0, so GAP exits to IDLE.
  - GAP: `st=0` for exactly `GAP_CYCLES` cycles. Then go to RUN if `remaining != 0`, else to IDLE.
- Counter widths:
  - `remaining` is 3 bits.
  - The gap counter and timeout counter are sized by `$clog2` of their parameter.
  - Both counters clear on state entry and never wrap; they stop at terminal count.
- Error flag:
  - `err` set and `err_clr` in the same cycle: set wins.
  - `err` is unaffected by new requests.

## Timing
- Reset values: `st=0`, `done=0`, `err=0`, `busy=0`, `req_ready=1`; FSM in IDLE; queue empty; all counters 0.
- All outputs are registered.
- Reset mid-burst: `st` drops on the next edge and queued requests are lost.
- Latency:
  - A request accepted at edge k into an empty queue with the FSM in IDLE gives `st=1` after edge k+1.
  - The queue has no fall-through.
- `over` sampled high at edge m (m beyond the blanking cycle): `st=0` after edge m.
- Burst-to-burst spacing within a request: exactly `GAP_CYCLES` cycles of `st=0`.
- Request-to-request spacing: at least 1 IDLE cycle of `st=0`, so the beeper is always cleared before the next burst.
- Simultaneous push and pop at full: the push is refused (`req_ready` reflects the pre-edge occupancy).
- Simultaneous push and pop at non-full: both happen and occupancy is unchanged.
- `done` is high for exactly one cycle, on the edge leaving RUN by completion or timeout.
- `busy` covers the whole request, including the trailing GAP after a timeout.

## Structure
- Package `beep_pkg` holds:
  - FSM state encodings (IDLE=2'd0, RUN=2'd1, GAP=2'd2).
  - `REQ_N_W=3`.
  - Default parameter values shared with the beeper/top level.
- Sub-module `beep_req_fifo`:
  - Synchronous FIFO, width `REQ_N_W`, depth `FIFO_DEPTH`.
  - Ports: push, pop, din, dout, full, empty.
  - Synchronous active-low reset.
- The FSM, counters and `err` logic live in `beep_seq`.

## Test plan
Bench parameters: `GAP_CYCLES=4`, `TIMEOUT_CYCLES=20`; the beeper model asserts `over` 10 cycles after `st` rises.
- Single request, `req_n=3`:
  - `st` shows 3 high bursts, each 10-11 cycles, separated by exactly 4 low cycles.
  - One `done` pulse after the third `over`.
  - `busy` falls the cycle after `done`.
- Queue fill: 5 back-to-back `req` with `req_n=1`:
  - The first 4 are accepted; `req_ready` is 0 on the 5th and that request is dropped.
  - Exactly 4 bursts and 4 `done` pulses follow.
- `req_n=0`, and `req` while full:
  - No `st` activity.
  - Occupancy unchanged.
  - No `done`.
- Model never asserts `over`, `req_n=2`:
  - `st` high for 20 cycles, then low.
  - `err=1` and one `done` pulse.
  - No second burst; IDLE after 4 gap cycles.
  - `err_clr` and a timeout on the same edge leave `err=1`; a later lone `err_clr` clears it.
- Stale `over`: model holds `over=1` into the first RUN cycle.
  - It is ignored; the burst still lasts until a fresh `over`.
- Reset asserted mid-RUN with 2 requests queued:
  - After the edge: `st=0`, `busy=0`, `req_ready=1`.
  - No further bursts after `rst_n` releases.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared types and defaults for the beep request sequencer and its request queue.
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int REQ_N_W            = 3;
    localparam int GAP_CYCLES_DEF     = 200;
    localparam int TIMEOUT_CYCLES_DEF = 2000;
    localparam int FIFO_DEPTH_DEF     = 4;

endpackage

// File: rtl/beep_req_fifo.sv
// Request queue holding burst counts; no fall-through, full/empty are registered.
module beep_req_fifo
    import beep_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [REQ_N_W-1:0] din,
    output logic [REQ_N_W-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [REQ_N_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [CW-1:0]      count_s;
    logic               full_r;
    logic               empty_r;
    logic               push_s;
    logic               pop_s;

    // Qualify push/pop against pre-edge occupancy and compute next occupancy.
    always_comb begin
        push_s  = push && !full_r;
        pop_s   = pop && !empty_r;
        count_s = count_r;
        if (push_s && !pop_s) begin
            count_s = count_r + 1'b1;
        end else if (!push_s && pop_s) begin
            count_s = count_r - 1'b1;
        end else begin
            count_s = count_r;
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_s;
            full_r  <= (count_s == CW'(DEPTH));
            empty_r <= (count_s == {CW{1'b0}});
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/beep_seq.sv
// Beep request sequencer: turns queued "beep N times" requests into N st/over
// bursts separated by a fixed st-low gap, with a watchdog on each burst.
module beep_seq
    import beep_pkg::*;
#(
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic [REQ_N_W-1:0] req_n,
    output logic               req_ready,
    output logic               st,
    input  logic               over,
    output logic               busy,
    output logic               done,
    output logic               err,
    input  logic               err_clr
);

    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_t             state_r;
    logic [REQ_N_W-1:0] remaining_r;
    logic [REQ_N_W-1:0] rem_dec_s;
    logic [GW-1:0]      gap_cnt_r;
    logic [TW-1:0]      to_cnt_r;
    logic               st_r;
    logic               done_r;
    logic               err_r;
    logic               busy_r;
    logic               push_s;
    logic               pop_s;
    logic [REQ_N_W-1:0] fifo_dout_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    // Zero-count requests never reach the queue; the queue itself refuses pushes when full.
    always_comb begin
        push_s    = req && (req_n != {REQ_N_W{1'b0}});
        pop_s     = (state_r == ST_IDLE) && !fifo_empty_s;
        rem_dec_s = remaining_r - 1'b1;
    end

    beep_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   (req_n),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sequencer FSM with its counters, error flag and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            remaining_r <= {REQ_N_W{1'b0}};
            gap_cnt_r   <= {GW{1'b0}};
            to_cnt_r    <= {TW{1'b0}};
            st_r        <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            busy_r <= (state_r != ST_IDLE) || !fifo_empty_s;
            if (err_clr) begin
                err_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        remaining_r <= fifo_dout_s;
                        to_cnt_r    <= {TW{1'b0}};
                        st_r        <= 1'b1;
                        state_r     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // to_cnt_r == 0 marks the blanking cycle where a stale over is ignored.
                    if ((to_cnt_r != {TW{1'b0}}) && over) begin
                        remaining_r <= rem_dec_s;
                        st_r        <= 1'b0;
                        if (rem_dec_s == {REQ_N_W{1'b0}}) begin
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            gap_cnt_r <= {GW{1'b0}};
                            state_r   <= ST_GAP;
                        end
                    end else if (to_cnt_r == TO_LAST) begin
                        err_r       <= 1'b1;
                        done_r      <= 1'b1;
                        remaining_r <= {REQ_N_W{1'b0}};
                        st_r        <= 1'b0;
                        gap_cnt_r   <= {GW{1'b0}};
                        state_r     <= ST_GAP;
                    end else begin
                        to_cnt_r <= to_cnt_r + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        if (remaining_r != {REQ_N_W{1'b0}}) begin
                            to_cnt_r <= {TW{1'b0}};
                            st_r     <= 1'b1;
                            state_r  <= ST_RUN;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 1'b1;
                    end
                end
                default: begin
                    st_r    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = ~fifo_full_s;
    assign st        = st_r;
    assign done      = done_r;
    assign err       = err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_beep_seq.sv
// Directed bench for beep_seq: beeper model on the st/over handshake plus a
// scoreboard of expected bursts per request, checked on every done pulse.
module tb_beep_seq;

    localparam int GAP = 4;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [2:0] req_n;
    logic       req_ready;
    logic       st;
    logic       over;
    logic       busy;
    logic       done;
    logic       err;
    logic       err_clr;

    beep_seq #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_n     (req_n),
        .req_ready (req_ready),
        .st        (st),
        .over      (over),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int sb[$];

    bit stale_mode = 1'b0;
    bit never_mode = 1'b0;
    int mcnt = 0;

    bit st_prev = 1'b0;
    bit done_prev = 1'b0;
    bit done_seen = 1'b0;
    int hi_len = 0;
    int lo_len = 0;
    int bursts_in_req = 0;
    int n_rises = 0;
    int n_done = 0;
    int len_lo = 10;
    int len_hi = 11;

    // Beeper model: over rises 10 cycles after st, held until st drops.
    always @(negedge clk) begin
        if (st !== 1'b1) begin
            mcnt = 0;
            over = stale_mode;
        end else begin
            mcnt = mcnt + 1;
            if (mcnt == 2 && stale_mode) over = 1'b0;
            if (mcnt == 10 && !never_mode) over = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle: advance to the falling edge and run the output monitor.
    task automatic tick();
        @(negedge clk);
        if (st === 1'b1 && !st_prev) begin
            n_rises++;
            if (bursts_in_req > 0) check("gap_len", lo_len, GAP);
            hi_len = 0;
        end
        if (st === 1'b0 && st_prev) begin
            bursts_in_req++;
            n_tests++;
            assert (hi_len >= len_lo && hi_len <= len_hi) else begin
                n_fail++;
                $error("FAIL burst_len: observed %0d expected %0d..%0d", hi_len, len_lo, len_hi);
            end
            lo_len = 0;
        end
        if (st === 1'b1) hi_len++; else lo_len++;
        st_prev = (st === 1'b1);
        done_seen = (done === 1'b1);
        if (done_seen) begin
            n_done++;
            check("done_one_cycle", done_prev, 0);
            check("done_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) check("bursts_per_req", bursts_in_req, sb.pop_front());
            bursts_in_req = 0;
        end
        done_prev = done_seen;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (done_seen) break;
        end
        check("done_within_budget", (i < budget), 1);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (sb.size() == 0 && busy === 1'b0 && st === 1'b0) break;
            tick();
        end
        check("idle_within_budget", (i < budget), 1);
    endtask

    initial begin
        int r0;
        int d0;
        int occ;
        bit exp_ready;
        rst_n = 1'b0; req = 1'b0; req_n = 3'd0; err_clr = 1'b0; over = 1'b0;
        repeat (3) tick();
        check("rst_st", st, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        rst_n = 1'b1;
        tick();

        // Single request of 3 bursts
        r0 = n_rises;
        req = 1'b1; req_n = 3'd3; sb.push_back(3);
        tick();
        check("lat_edge_k", st, 0);
        req = 1'b0;
        tick();
        check("lat_edge_k1", st, 1);
        wait_done(200);
        check("busy_at_done", busy, 1);
        tick();
        check("busy_after_done", busy, 0);
        check("single_rises", n_rises - r0, 3);

        // Queue fill behind a running request
        r0 = n_rises; d0 = n_done;
        req = 1'b1; req_n = 3'd1; sb.push_back(1);
        tick();
        req = 1'b0;
        tick();
        check("fill_running", st, 1);
        occ = 0;
        for (int i = 0; i < 5; i++) begin
            req = 1'b1; req_n = 3'd1;
            exp_ready = (occ < 4);
            check("fill_ready", req_ready, exp_ready);
            if (exp_ready) begin
                sb.push_back(1);
                occ++;
            end
            tick();
        end
        req = 1'b0;
        check("full_ready", req_ready, 0);
        wait_idle(300);
        check("fill_dones", n_done - d0, 5);
        check("fill_rises", n_rises - r0, 5);

        // Zero-count request is a no-op
        r0 = n_rises; d0 = n_done;
        req = 1'b1; req_n = 3'd0;
        tick();
        req = 1'b0;
        repeat (30) tick();
        check("zero_rises", n_rises - r0, 0);
        check("zero_dones", n_done - d0, 0);
        check("zero_busy", busy, 0);
        check("zero_ready", req_ready, 1);

        // Watchdog timeout abandons a 2-burst request
        never_mode = 1'b1; len_lo = TMO; len_hi = TMO;
        r0 = n_rises;
        req = 1'b1; req_n = 3'd2; sb.push_back(1);
        tick();
        req = 1'b0;
        wait_done(100);
        check("tmo_err", err, 1);
        repeat (4) tick();
        check("tmo_gap_busy", busy, 1);
        check("tmo_gap_st", st, 0);
        tick();
        check("tmo_idle_busy", busy, 0);
        check("tmo_rises", n_rises - r0, 1);

        // err_clr coinciding with a timeout: set wins
        req = 1'b1; req_n = 3'd1; sb.push_back(1); err_clr = 1'b1;
        tick();
        req = 1'b0;
        check("err_clr_clears", err, 0);
        wait_done(100);
        err_clr = 1'b0;
        check("err_set_wins", err, 1);
        tick();
        check("err_sticky", err, 1);
        wait_idle(50);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_lone_clr", err, 0);
        never_mode = 1'b0; len_lo = 10; len_hi = 11;

        // Stale over held into the first RUN cycle
        stale_mode = 1'b1;
        repeat (2) tick();
        req = 1'b1; req_n = 3'd1; sb.push_back(1);
        tick();
        req = 1'b0;
        wait_done(100);
        stale_mode = 1'b0;
        wait_idle(50);

        // Reset mid-RUN with two requests queued
        len_lo = 0; len_hi = 100;
        req = 1'b1; req_n = 3'd3;
        tick();
        req_n = 3'd1;
        tick();
        tick();
        req = 1'b0;
        repeat (3) tick();
        check("pre_rst_st", st, 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_st", st, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", req_ready, 1);
        sb.delete();
        bursts_in_req = 0;
        rst_n = 1'b1;
        r0 = n_rises;
        repeat (40) tick();
        check("post_rst_rises", n_rises - r0, 0);
        check("post_rst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
